// File: rtl/signal_phase_sched.sv
// Two-road intersection phase scheduler.
// Sequences NS/EW lights through green, yellow and all-red phases on the 1 s
// tick. A debounced congestion flag picks which road gets the long green, and
// the mode is only adopted when the cycle wraps back to NS green. force_red
// preempts everything into an all-red HOLD. Every output is registered.
module signal_phase_sched #(
    parameter int GREEN_LONG  = 30,
    parameter int GREEN_SHORT = 10,
    parameter int YELLOW_T    = 3,
    parameter int ALLRED_T    = 1,
    parameter int FILTER_N    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_sec,
    input  logic       congest_valid,
    input  logic       congest_sel,
    input  logic       force_red,
    output logic [1:0] light_ns,
    output logic [1:0] light_ew,
    output logic       tr_mode,
    output logic [4:0] remain_sec,
    output logic       phase_valid,
    output logic       mode_valid
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_A     = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_B     = 3'd5,
        HOLD      = 3'd6
    } phase_t;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    // Counter must be able to hold FILTER_N-1 before the final agreeing sample.
    localparam int CNT_W = (FILTER_N < 2) ? 1 : $clog2(FILTER_N + 1);

    phase_t           state_reg, state_next;
    phase_t           entry_target;
    logic             enter_phase;
    logic [4:0]       remain_reg, remain_next;
    logic             phase_valid_reg, phase_valid_next;
    logic             tr_mode_reg, tr_mode_next;
    logic             mode_valid_reg, mode_valid_next;
    logic [1:0]       light_ns_reg, light_ns_next;
    logic [1:0]       light_ew_reg, light_ew_next;
    logic             pend_mode_reg, pend_mode_next;
    logic [CNT_W-1:0] agree_cnt_reg, agree_cnt_next;

    // Duration loaded on entry; mode 1 favours the main (NS) road.
    function automatic logic [4:0] phase_duration(input phase_t p, input logic mode);
        case (p)
            NS_GREEN:            return mode ? 5'(GREEN_LONG) : 5'(GREEN_SHORT);
            EW_GREEN:            return mode ? 5'(GREEN_SHORT) : 5'(GREEN_LONG);
            NS_YELLOW, EW_YELLOW: return 5'(YELLOW_T);
            RED_A, RED_B:        return 5'(ALLRED_T);
            default:             return 5'd0;
        endcase
    endfunction

    // Normal ring order; HOLD never advances on a tick.
    function automatic phase_t phase_successor(input phase_t p);
        case (p)
            NS_GREEN:  return NS_YELLOW;
            NS_YELLOW: return RED_A;
            RED_A:     return EW_GREEN;
            EW_GREEN:  return EW_YELLOW;
            EW_YELLOW: return RED_B;
            RED_B:     return NS_GREEN;
            default:   return RED_B;
        endcase
    endfunction

    // State register plus all registered outputs and the congestion filter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= RED_B;
            remain_reg      <= 5'(ALLRED_T);
            phase_valid_reg <= 1'b0;
            tr_mode_reg     <= 1'b0;
            mode_valid_reg  <= 1'b0;
            light_ns_reg    <= LIGHT_RED;
            light_ew_reg    <= LIGHT_RED;
            pend_mode_reg   <= 1'b0;
            agree_cnt_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            remain_reg      <= remain_next;
            phase_valid_reg <= phase_valid_next;
            tr_mode_reg     <= tr_mode_next;
            mode_valid_reg  <= mode_valid_next;
            light_ns_reg    <= light_ns_next;
            light_ew_reg    <= light_ew_next;
            pend_mode_reg   <= pend_mode_next;
            agree_cnt_reg   <= agree_cnt_next;
        end
    end

    // Phase sequencing: preemption first, then HOLD release, then countdown.
    always_comb begin
        state_next       = state_reg;
        remain_next      = remain_reg;
        phase_valid_next = 1'b0;
        tr_mode_next     = tr_mode_reg;
        mode_valid_next  = 1'b0;
        enter_phase      = 1'b0;
        entry_target     = state_reg;

        if (force_red) begin
            if (state_reg != HOLD) begin
                state_next       = HOLD;
                remain_next      = 5'd0;
                phase_valid_next = 1'b1;
            end
        end else if (state_reg == HOLD) begin
            enter_phase  = 1'b1;
            entry_target = RED_B;
        end else if (tick_sec) begin
            if (remain_reg > 5'd1) begin
                remain_next = remain_reg - 5'd1;
            end else begin
                enter_phase  = 1'b1;
                entry_target = phase_successor(state_reg);
            end
        end

        if (enter_phase) begin
            state_next       = entry_target;
            phase_valid_next = 1'b1;
            // The pending mode as it stood before this cycle's sample is adopted.
            if (entry_target == NS_GREEN) begin
                tr_mode_next    = pend_mode_reg;
                mode_valid_next = (pend_mode_reg != tr_mode_reg);
            end
            remain_next = phase_duration(entry_target, tr_mode_next);
        end
    end

    // Light decode of the upcoming state so the lights are registered too.
    always_comb begin
        light_ns_next = LIGHT_RED;
        light_ew_next = LIGHT_RED;
        case (state_next)
            NS_GREEN:  light_ns_next = LIGHT_GREEN;
            NS_YELLOW: light_ns_next = LIGHT_YELLOW;
            EW_GREEN:  light_ew_next = LIGHT_GREEN;
            EW_YELLOW: light_ew_next = LIGHT_YELLOW;
            default: begin
                light_ns_next = LIGHT_RED;
                light_ew_next = LIGHT_RED;
            end
        endcase
    end

    // Congestion debounce: FILTER_N consecutive disagreeing samples flip pend_mode.
    always_comb begin
        pend_mode_next = pend_mode_reg;
        agree_cnt_next = agree_cnt_reg;
        if (congest_valid) begin
            if (congest_sel == pend_mode_reg) begin
                agree_cnt_next = '0;
            end else if (agree_cnt_reg == CNT_W'(FILTER_N - 1)) begin
                pend_mode_next = congest_sel;
                agree_cnt_next = '0;
            end else begin
                agree_cnt_next = agree_cnt_reg + 1'b1;
            end
        end
    end

    assign light_ns    = light_ns_reg;
    assign light_ew    = light_ew_reg;
    assign tr_mode     = tr_mode_reg;
    assign remain_sec  = remain_reg;
    assign phase_valid = phase_valid_reg;
    assign mode_valid  = mode_valid_reg;

endmodule
